vram_arbiter: RTL and testbench

//  Shares one single-port synchronous video RAM between VGA scan-out and a host (draw/CPU) port.

---
 rtl/vram_arbiter_if.sv | 24 ++
 rtl/vram_arbiter.sv | 106 ++++++++++
 tb/tb_vram_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Host-side request/response bundle for the VRAM arbiter.
// The host holds req and all fields stable until ack.
interface vram_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              host_req;
  logic              host_we;
  logic [9:0]        host_x;
  logic [9:0]        host_y;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic              host_err;
  logic [DATA_W-1:0] host_rdata;

  modport master (
    output host_req, host_we, host_x, host_y, host_wdata,
    input  host_ack, host_err, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_x, host_y, host_wdata,
    output host_ack, host_err, host_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM sharing between VGA scan-out and a host port.
// Display owns pixel-enable slots in active video; host issues in any other cycle.
module vram_arbiter #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              blank,
  input  logic              hsync,
  input  logic              vsync,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  vram_arbiter_if.slave     host,
  output logic [DATA_W-1:0] pixel_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              blank_o
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);
  localparam logic [9:0]        H_LIM   = 10'(H_RES);
  localparam logic [9:0]        V_LIM   = 10'(V_RES);

  state_t            state, state_nx;
  logic              disp_slot, host_oob, issue;
  logic              err_q, rd_q;
  logic [ADDR_W-1:0] disp_addr, host_addr;
  logic              en_d1, blank_d1, hs_d1, vs_d1;

  assign disp_slot = pix_en & ~blank;
  assign host_oob  = (host.host_x >= H_LIM) | (host.host_y >= V_LIM);
  // Operands widened to ADDR_W before the multiply so the product never truncates.
  assign disp_addr = ADDR_W'(vcount) * H_RES_A + ADDR_W'(hcount);
  assign host_addr = ADDR_W'(host.host_y) * H_RES_A + ADDR_W'(host.host_x);
  assign ram_wdata = host.host_wdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    ram_we   = 1'b0;
    ram_addr = disp_slot ? disp_addr : host_addr;
    case (state)
      IDLE: if (host.host_req && !disp_slot) begin
        issue    = 1'b1;
        ram_we   = host.host_we & ~host_oob;
        state_nx = WAIT;
      end
      WAIT:    state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_q           <= 1'b0;
      rd_q            <= 1'b0;
      host.host_ack   <= 1'b0;
      host.host_err   <= 1'b0;
      host.host_rdata <= '0;
    end else begin
      if (issue) begin
        err_q <= host_oob;
        rd_q  <= ~host.host_we & ~host_oob;
      end
      host.host_ack <= (state == WAIT);
      host.host_err <= (state == WAIT) & err_q;
      if (state == WAIT && rd_q) host.host_rdata <= ram_rdata;
    end

  // Two-stage alignment: stage 1 tracks the fetch slot, stage 2 lands with RAM data.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      en_d1    <= 1'b0;
      blank_d1 <= 1'b1;
      hs_d1    <= 1'b1;
      vs_d1    <= 1'b1;
      pixel_o  <= '0;
      blank_o  <= 1'b1;
      hsync_o  <= 1'b1;
      vsync_o  <= 1'b1;
    end else begin
      en_d1    <= pix_en;
      blank_d1 <= blank;
      hs_d1    <= hsync;
      vs_d1    <= vsync;
      blank_o  <= blank_d1;
      hsync_o  <= hs_d1;
      vsync_o  <= vs_d1;
      if (blank_d1)   pixel_o <= '0;
      else if (en_d1) pixel_o <= ram_rdata;
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: behavioural sync RAM plus a host response scoreboard.
module tb_vram_arbiter;
  localparam int H_RES = 640, V_RES = 480, DATA_W = 8, ADDR_W = 19;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              pix_en, blank, hsync, vsync;
  logic [9:0]        hcount, vcount;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata, ram_rdata, pixel_o;
  logic              hsync_o, vsync_o, blank_o;

  vram_arbiter_if #(.DATA_W(DATA_W)) hif ();

  vram_arbiter #(.H_RES(H_RES), .V_RES(V_RES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
    .blank(blank), .hsync(hsync), .vsync(vsync), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .host(hif.slave), .pixel_o(pixel_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .blank_o(blank_o)
  );

  // Unwritten locations return a fixed pattern; two cells are preloaded.
  function automatic logic [7:0] ram_init(input int a);
    if (a == 641)    return 8'hA5;
    if (a == 307199) return 8'h77;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  logic [7:0] wmem [int];
  function automatic logic [7:0] rd(input int a);
    return wmem.exists(a) ? wmem[a] : ram_init(a);
  endfunction

  always @(posedge clk) begin
    ram_rdata <= rd(int'(ram_addr));
    if (ram_we) wmem[int'(ram_addr)] = ram_wdata;
  end

  typedef struct { logic err; logic rd; logic [7:0] data; } exp_t;
  exp_t sbq [$];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nc(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic req(input logic we, input int x, input int y, input logic [7:0] d);
    hif.host_req = 1'b1; hif.host_we = we;
    hif.host_x = 10'(x); hif.host_y = 10'(y); hif.host_wdata = d;
  endtask

  task automatic push(input logic err, input logic r, input logic [7:0] d);
    exp_t e;
    e.err = err; e.rd = r; e.data = d;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && hif.host_ack) begin
      if (sbq.size() == 0) chk("spurious_ack", 32'(sbq.size()), 1);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_err", hif.host_err, e.err);
        if (e.rd) chk("sb_rdata", hif.host_rdata, e.data);
      end
    end
  end

  initial begin
    hif.host_req = 0; hif.host_we = 0; hif.host_x = 0; hif.host_y = 0; hif.host_wdata = 0;
    pix_en = 0; blank = 1; hsync = 1; vsync = 1; hcount = 0; vcount = 0;
    repeat (2) @(posedge clk);
    smp();
    chk("rst_ack", hif.host_ack, 0);   chk("rst_err", hif.host_err, 0);
    chk("rst_rdata", hif.host_rdata, 0); chk("rst_pixel", pixel_o, 0);
    chk("rst_hs", hsync_o, 1); chk("rst_vs", vsync_o, 1); chk("rst_blank", blank_o, 1);
    nc(); rst_n = 1;
    nc(); smp();

    // display fetch of (1,1)
    nc(); pix_en = 1; blank = 0; hcount = 1; vcount = 1; smp();
    chk("disp_addr", ram_addr, 641); chk("disp_we", ram_we, 0);
    nc(); pix_en = 0; smp();
    nc(); pix_en = 1; hcount = 2; smp();
    chk("pix_T2", pixel_o, 8'hA5); chk("blank_o_T2", blank_o, 0);
    nc(); pix_en = 0; smp(); chk("pix_T3", pixel_o, 8'hA5);

    // host write during active video stalls one cycle
    nc(); pix_en = 1; hcount = 3; req(1, 10, 2, 8'h3C); push(0, 0, 0); smp();
    chk("pix_T4", pixel_o, ram_init(642)); chk("stall_addr", ram_addr, 643); chk("stall_we", ram_we, 0);
    nc(); pix_en = 0; smp(); chk("wr_addr", ram_addr, 1290); chk("wr_we", ram_we, 1);
    nc(); pix_en = 1; hcount = 4; smp();
    chk("wait_disp_addr", ram_addr, 644); chk("wait_disp_we", ram_we, 0); chk("pix_643", pixel_o, ram_init(643));
    nc(); pix_en = 0; smp(); chk("wr_ack", hif.host_ack, 1); chk("wr_err", hif.host_err, 0);
    nc(); hif.host_req = 0; pix_en = 1; blank = 1; smp();

    // blanking read of last pixel
    nc(); pix_en = 0; smp();
    nc(); pix_en = 1; req(0, 639, 479, 0); push(0, 1, 8'h77); smp();
    chk("rd_addr", ram_addr, 307199); chk("rd_we", ram_we, 0);
    nc(); pix_en = 0; smp();
    nc(); pix_en = 1; smp(); chk("rd_ack", hif.host_ack, 1); chk("rd_data", hif.host_rdata, 8'h77);
    nc(); hif.host_req = 0; pix_en = 0; smp();

    // read back the earlier write
    nc(); pix_en = 1; req(0, 10, 2, 0); push(0, 1, 8'h3C); smp(); chk("rb_addr", ram_addr, 1290);
    nc(); pix_en = 0; smp();
    nc(); pix_en = 1; smp(); chk("rb_ack", hif.host_ack, 1);
    nc(); hif.host_req = 0; pix_en = 0; smp();
    chk("blank_pix", pixel_o, 0); chk("blank_o", blank_o, 1);

    // out-of-range write
    nc(); pix_en = 1; req(1, 640, 0, 8'hFF); push(1, 0, 0); smp(); chk("oob_we0", ram_we, 0);
    nc(); pix_en = 0; smp(); chk("oob_we1", ram_we, 0);
    nc(); pix_en = 1; smp(); chk("oob_we2", ram_we, 0);
    chk("oob_ack", hif.host_ack, 1); chk("oob_err", hif.host_err, 1);
    nc(); hif.host_req = 0; pix_en = 0; smp(); chk("ack_pulse", hif.host_ack, 0);

    // reset mid-frame while a host read sits in WAIT
    nc(); pix_en = 1; blank = 0; hcount = 1; vcount = 1; smp();
    nc(); pix_en = 0; req(0, 5, 5, 0); smp(); chk("rst_issue_addr", ram_addr, 3205);
    nc(); pix_en = 1; hcount = 2; smp();
    chk("pre_rst_pix", pixel_o, 8'hA5); chk("pre_rst_blank", blank_o, 0);
    #1 rst_n = 0; hif.host_req = 0;
    #1;
    chk("mid_rst_ack", hif.host_ack, 0); chk("mid_rst_err", hif.host_err, 0);
    chk("mid_rst_rdata", hif.host_rdata, 0); chk("mid_rst_pix", pixel_o, 0);
    chk("mid_rst_hs", hsync_o, 1); chk("mid_rst_vs", vsync_o, 1); chk("mid_rst_blank", blank_o, 1);
    nc(); nc(); rst_n = 1; pix_en = 0; blank = 1;
    for (int i = 0; i < 4; i++) begin
      nc(); pix_en = ~pix_en; smp(); chk("no_ack_after_rst", hif.host_ack, 0);
    end

    // sync/blank delay alignment
    nc(); pix_en = 1; hsync = 0; vsync = 0; blank = 0; hcount = 0; vcount = 0; smp();
    chk("hs_C0", hsync_o, 1);
    nc(); pix_en = 0; hsync = 1; smp();
    chk("hs_C1", hsync_o, 1); chk("vs_C1", vsync_o, 1); chk("bl_C1", blank_o, 1); chk("pix_C1", pixel_o, 0);
    nc(); pix_en = 1; hcount = 1; smp();
    chk("hs_C2", hsync_o, 0); chk("vs_C2", vsync_o, 0); chk("bl_C2", blank_o, 0); chk("pix_C2", pixel_o, ram_init(0));
    nc(); pix_en = 0; blank = 1; vsync = 1; smp();
    chk("hs_C3", hsync_o, 1); chk("vs_C3", vsync_o, 0); chk("bl_C3", blank_o, 0); chk("pix_C3", pixel_o, ram_init(0));
    nc(); pix_en = 1; smp();
    chk("vs_C4", vsync_o, 0); chk("bl_C4", blank_o, 0); chk("pix_C4", pixel_o, ram_init(1));
    nc(); pix_en = 0; smp();
    chk("vs_C5", vsync_o, 1); chk("bl_C5", blank_o, 1); chk("pix_C5", pixel_o, 0);

    nc(); smp();
    chk("sb_empty", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
